// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl
//   Sequences a two-line cascaded line buffer plus a 3x3 window shift register
//   for a WIDTH x HEIGHT raster stream. It tracks the column and row of the
//   next expected pixel and gates line-buffer writes to the active frame. It
//   flags a complete 3x3 neighbourhood one cycle after the pixel that
//   completes it.
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous active-low reset
//   start_i       one-cycle pulse, arms a new frame (honoured only in IDLE)
//   valid_i       a pixel is on the stream this cycle
//   lb0_done_i    first line buffer full / reading
//   lb1_done_i    second (cascaded) line buffer full / reading
//   lb_we_o       write enable to line buffers and window (combinational)
//   win_valid_o   window holds a complete 3x3 neighbourhood (registered)
//   col_o, row_o  position of the next expected pixel
//   busy_o        frame in progress (FILL or RUN)
//   frame_done_o  one-cycle pulse after the last pixel of a frame
//   err_o         sticky: line buffers not both done when the window went live
module line_buffer_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       valid_i,
  input  logic       lb0_done_i,
  input  logic       lb1_done_i,
  output logic       lb_we_o,
  output logic       win_valid_o,
  output logic [9:0] col_o,
  output logic [8:0] row_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       err_o
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  localparam logic [9:0] COL_LAST = 10'(WIDTH - 1);
  localparam logic [8:0] ROW_LAST = 9'(HEIGHT - 1);

  state_t     state_q, state_d;
  logic [9:0] col_q, col_d;
  logic [8:0] row_q, row_d;
  logic       win_q, win_d;
  logic       fd_q, fd_d;
  logic       err_q, err_d;

  logic accept;
  logic eol;

  // A pixel is consumed only while a frame is open; anything else is dropped.
  assign accept = valid_i && ((state_q == FILL) || (state_q == RUN));
  assign eol    = accept && (col_q == COL_LAST);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    fd_d    = 1'b0;
    // Window is complete once two full rows and two columns of the
    // current row sit behind the pixel just written.
    win_d   = accept && (row_q >= 9'd2) && (col_q >= 10'd2);

    if (accept) begin
      col_d = eol ? 10'd0 : col_q + 10'd1;
      row_d = eol ? row_q + 9'd1 : row_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FILL;
          col_d   = 10'd0;
          row_d   = 9'd0;
        end
      end
      FILL: begin
        // Both buffers must be primed exactly when row 1 completes.
        if (eol && (row_q == 9'd1)) begin
          state_d = RUN;
          if (!(lb0_done_i && lb1_done_i)) err_d = 1'b1;
        end
      end
      RUN: begin
        if (eol && (row_q == ROW_LAST)) begin
          state_d = DONE;
          col_d   = 10'd0;
          row_d   = 9'd0;
          fd_d    = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= 10'd0;
      row_q   <= 9'd0;
      win_q   <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign lb_we_o      = accept;
  assign win_valid_o  = win_q;
  assign col_o        = col_q;
  assign row_o        = row_q;
  assign busy_o       = (state_q == FILL) || (state_q == RUN);
  assign frame_done_o = fd_q;
  assign err_o        = err_q;

endmodule

// File: doc/line_buffer_ctrl.md
LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 Parameter WIDTH, default 640: pixels per image row; line-buffer DEPTH equals WIDTH.
REQ-002 Parameter HEIGHT, default 480: rows per frame.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  one-cycle pulse that arms the controller for a new frame.
REQ-006 valid_i  input  1  a pixel is present on the stream this cycle.
REQ-007 lb0_done_i  input  1  done flag of first line buffer (full, reading).
REQ-008 lb1_done_i  input  1  done flag of second (cascaded) line buffer.
REQ-009 lb_we_o  output  1  write enable to both line buffers and the 3x3 window shift register.
REQ-010 win_valid_o  output  1  3x3 window holds a complete neighbourhood.
REQ-011 col_o  output  10  column index of the next pixel expected.
REQ-012 row_o  output  9  row index of the next pixel expected.
REQ-013 busy_o  output  1  high in FILL or RUN.
REQ-014 frame_done_o  output  1  one-cycle pulse after the last pixel of a frame.
REQ-015 err_o  output  1  sticky line-buffer sequencing error.

Function
REQ-016 FSM states: IDLE, FILL, RUN, DONE; the state register shall be the only source of busy_o.
REQ-017 IDLE -> FILL on start_i; start_i in any other state shall be ignored.
REQ-018 lb_we_o shall equal valid_i AND (state is FILL or RUN), combinationally, same cycle; in IDLE/DONE valid_i shall be dropped with no counter change.
REQ-019 Each accepted pixel shall increment col; col == WIDTH-1 shall wrap col to 0 and increment row.
REQ-020 FILL -> RUN on the accepted pixel that moves row from 1 to 2 (2*WIDTH pixels accepted).
REQ-021 On the FILL->RUN transition lb0_done_i and lb1_done_i shall both be 1; otherwise err_o shall set and stay set until reset.
REQ-022 win_valid_o shall be registered: high in cycle N+1 if and only if a pixel accepted in cycle N had row >= 2 and col >= 2 (pre-increment values).
REQ-023 The accepted pixel at row HEIGHT-1, col WIDTH-1 shall move RUN -> DONE, return col/row to 0, and produce that pixel's win_valid_o in the following cycle.
REQ-024 DONE shall last exactly one cycle with frame_done_o = 1, then go to IDLE; lb_we_o = 0 in DONE.
REQ-025 Gaps in valid_i (bubbles) shall freeze counters, state and win_valid_o = 0 for that following cycle; no timeout.
REQ-026 start_i coincident with the DONE cycle shall be ignored; a new frame requires start_i in IDLE.
REQ-027 Counter arithmetic shall be unsigned; WIDTH <= 1024, HEIGHT <= 512, both >= 3.

Reset
REQ-028 rst low shall immediately force state IDLE, col_o = 0, row_o = 0, win_valid_o = 0, frame_done_o = 0, err_o = 0, busy_o = 0, lb_we_o = 0, regardless of clk.
REQ-029 Reset asserted mid-frame shall abandon the frame; no frame_done_o pulse shall follow.
REQ-030 After rst deasserts, the controller shall remain in IDLE until start_i.

Verification
REQ-031 WIDTH=8, HEIGHT=4, start then 32 back-to-back pixels -> first win_valid_o one cycle after pixel 19 (row2,col2); 12 win_valid_o pulses total; frame_done_o one cycle after pixel 32.
REQ-032 valid_i high for 5 cycles in IDLE -> lb_we_o stays 0, col_o/row_o stay 0.
REQ-033 Same frame with valid_i toggled every other cycle -> identical win_valid_o count (12), each one cycle after its pixel; frame_done_o after 32nd accepted pixel.
REQ-034 lb1_done_i held 0 at the FILL->RUN transition -> err_o = 1 and held through frame end until rst.
REQ-035 rst pulsed low after 20 pixels -> all outputs 0 asynchronously; no frame_done_o; a following start plus 32 pixels -> normal REQ-031 result.
REQ-036 start_i pulsed during RUN and during DONE -> no effect on counters or state.
